// File: rtl/cpu_opfetch.sv
// Operand-fetch stage: issues register-file reads, waits out the one-cycle read,
// forwards writeback data the register file cannot return yet, and registers operands for execute.
module cpu_opfetch #(
  parameter int PAYLOAD_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [3:0]           in_src1,
  input  logic [3:0]           in_src2,
  input  logic [3:0]           in_dst,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic [3:0]           rf_sel1,
  output logic [3:0]           rf_sel2,
  input  logic [31:0]          rf_reg1,
  input  logic [31:0]          rf_reg2,
  input  logic                 wb_en,
  input  logic [3:0]           wb_sel,
  input  logic [31:0]          wb_data,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [31:0]          out_op1,
  output logic [31:0]          out_op2,
  output logic [3:0]           out_dst,
  output logic [PAYLOAD_W-1:0] out_payload
);

  typedef struct packed {
    logic [3:0]           src1;
    logic [3:0]           src2;
    logic [3:0]           dst;
    logic [PAYLOAD_W-1:0] payload;
  } req_t;

  req_t        in_req, a_req, b_req;
  logic        a_vld, b_vld;
  logic [31:0] b_op1, b_op2;
  logic        byp1, byp2;
  logic [31:0] bdata1, bdata2;
  logic        a_move, accept;
  logic [31:0] a_val1, a_val2, b_ld1, b_ld2;

  // Writeback to a nonzero register matching src; R0 never hits.
  function automatic logic wb_hit(input logic en, input logic [3:0] sel, input logic [3:0] src);
    return en && (sel == src) && (src != 4'd0);
  endfunction

  assign in_req = '{src1: in_src1, src2: in_src2, dst: in_dst, payload: in_payload};
  assign a_move = a_vld && (!b_vld || out_rdy);
  assign in_rdy = !a_vld || a_move;
  assign accept = in_vld && in_rdy;

  // A stalled keeps its selects so the register file re-reads them each cycle.
  assign rf_sel1 = in_rdy ? in_src1 : a_req.src1;
  assign rf_sel2 = in_rdy ? in_src2 : a_req.src2;

  assign a_val1 = (a_req.src1 == 4'd0) ? 32'd0 : (byp1 ? bdata1 : rf_reg1);
  assign a_val2 = (a_req.src2 == 4'd0) ? 32'd0 : (byp2 ? bdata2 : rf_reg2);
  assign b_ld1  = wb_hit(wb_en, wb_sel, a_req.src1) ? wb_data : a_val1;
  assign b_ld2  = wb_hit(wb_en, wb_sel, a_req.src2) ? wb_data : a_val2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vld  <= 1'b0;
      b_vld  <= 1'b0;
      a_req  <= '0;
      b_req  <= '0;
      b_op1  <= '0;
      b_op2  <= '0;
      byp1   <= 1'b0;
      byp2   <= 1'b0;
      bdata1 <= '0;
      bdata2 <= '0;
    end else begin
      byp1   <= !flush && wb_hit(wb_en, wb_sel, rf_sel1);
      byp2   <= !flush && wb_hit(wb_en, wb_sel, rf_sel2);
      bdata1 <= wb_data;
      bdata2 <= wb_data;
      if (flush) begin
        a_vld <= 1'b0;
        b_vld <= 1'b0;
      end else begin
        if (a_move) begin
          b_vld <= 1'b1;
          b_req <= a_req;
          b_op1 <= b_ld1;
          b_op2 <= b_ld2;
        end else if (b_vld && out_rdy) begin
          b_vld <= 1'b0;
        end else if (b_vld) begin
          // Held output tracks architectural state through writebacks.
          if (wb_hit(wb_en, wb_sel, b_req.src1)) b_op1 <= wb_data;
          if (wb_hit(wb_en, wb_sel, b_req.src2)) b_op2 <= wb_data;
        end
        if (accept) begin
          a_vld <= 1'b1;
          a_req <= in_req;
        end else if (a_move) begin
          a_vld <= 1'b0;
        end
      end
    end
  end

  assign out_vld     = b_vld;
  assign out_op1     = b_op1;
  assign out_op2     = b_op2;
  assign out_dst     = b_req.dst;
  assign out_payload = b_req.payload;

endmodule

// File: doc/cpu_opfetch.md
# cpu_opfetch

Operand-fetch stage between instruction decode and execute in the CPU pipeline. Accepts decoded requests with valid/ready and drives the register file's read selects. The register file has a one-cycle registered read, so this block waits out that latency and forwards same-cycle writeback data the register file cannot return yet. It delivers operands to execute through a registered valid/ready output, sustaining one request per cycle.

## Interface
- PAYLOAD_W, 32: width of opaque decoded-instruction payload passed through unchanged.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; drops all in-flight requests.
- in_vld  in  1  request valid.
- in_rdy  out  1  stage can accept.
- in_src1, in_src2  in  4  source register indices.
- in_dst  in  4  destination index, passed through.
- in_payload  in  PAYLOAD_W  passed through.
- rf_sel1, rf_sel2  out  4  register-file read selects.
- rf_reg1, rf_reg2  in  32  register-file registered read data, one cycle after select.
- wb_en  in  1  register-file write enable, snooped.
- wb_sel  in  4  register-file write index, snooped.
- wb_data  in  32  register-file write data, snooped.
- out_vld  out  1  operands valid.
- out_rdy  in  1  execute accepts.
- out_op1, out_op2  out  32  operand values.
- out_dst  out  4  passed-through destination index.
- out_payload  out  PAYLOAD_W  passed-through payload.

## Operation
- Two slots: A (waiting on register-file read), B (output register). Each slot holds a valid bit, src1/src2, dst and payload. B also holds op1/op2.
- B advances when B_vld && out_rdy. A moves to B when A_vld && (!B_vld || out_rdy).
- in_rdy = !A_vld || A moves to B (combinational).
- A request is accepted on an edge where in_vld && in_rdy. It loads into A, and A_vld is set.
- Select mux: rf_sel1 = in_rdy ? in_src1 : A_src1. rf_sel2 is formed the same way. While A is stalled, its selects are held, so the register file re-reads the same registers every cycle.
- Bypass registers: every edge, byp1 <= wb_en && wb_sel==rf_sel1 && rf_sel1!=0, and bdata1 <= wb_data. Port 2 works the same way.
- A operand value: if src==0, the value is 0. Otherwise it is bdata when byp is set, else rf_reg.
- B load value: if wb_en && wb_sel==A_src && A_src!=0 on the same edge, load wb_data. Otherwise load the A operand value.
- B stall snoop: if B stays valid and not consumed, and wb_en && wb_sel==B_src && B_src!=0, op is overwritten with wb_data. B operands therefore always reflect the latest architectural value.
- R0: operand is always 0 regardless of register-file content or writes to index 0. R0 is never bypassed.
- src1==src2: both ports use identical logic and produce identical values.
- flush: clears A_vld, B_vld, byp1 and byp2 at the edge and takes priority over accept. in_rdy is unaffected by flush in the flush cycle, but any request accepted on that edge is discarded.

## Timing
- Reset: A_vld=0, B_vld=0, out_vld=0, out_op1/out_op2=0, out_dst=0, out_payload=0, byp1/byp2=0.
- in_rdy=1 and rf_sel1/rf_sel2 follow in_src1/in_src2 immediately after reset.
- Latency: request accepted at end of cycle 0 → out_vld in cycle 2 with correct operands.
- Throughput: 1 request per cycle when out_rdy is held high.
- Full: A and B valid with out_rdy=0 → in_rdy=0, and B contents hold with snoop updates only.
- out_vld is high from B load until the edge where out_rdy=1. Output fields are stable while out_vld=1 && !out_rdy, except for snoop updates to op1/op2.
- Reset asserted mid-operation clears everything asynchronously. There is no partial output.

## Test plan
- Basic read: register file holds R3=0x11, R5=0x22. Send src1=3, src2=5, dst=7 → out_vld in cycle 2 with op1=0x11, op2=0x22, dst=7.
- Same-edge bypass: accept src1=4 on the edge where wb writes R4=0xDEAD → op1=0xDEAD. Also write R4=0xBEEF on the next edge, while A is transferring to B → op1=0xBEEF.
- R0: src1=0 while wb writes index 0 with 0xFFFF → op1=0.
- Stall snoop: hold out_rdy=0 with B holding src2=9. Write R9=0x1234 → op2 becomes 0x1234. Then raise out_rdy → one transfer with op2=0x1234.
- Back-to-back with backpressure: 4 requests, out_rdy toggling 1,0,0,1,… → in_rdy=0 exactly when A and B are full, and outputs appear in order with none lost or duplicated.
- Flush and reset: flush with A and B full → out_vld=0 next cycle and in_rdy=1. Assert rst_n=0 mid-stream → all outputs 0 at once.
